// File: rtl/decodifica_hamming.sv
// Hamming(15,11) single-error-correcting decoder: a two-stage valid/ready
// pipeline (syndrome, then correct and extract) plus a saturating error counter.
module decodifica_hamming (
    input  logic        clk,
    input  logic        rst,
    input  logic        entrada_valida,
    input  logic [14:0] entrada,
    output logic        entrada_pronta,
    output logic [10:0] saida,
    output logic        saida_valida,
    input  logic        saida_pronta,
    output logic        erro_corrigido,
    output logic [3:0]  sindrome,
    input  logic        limpa_contador,
    output logic [7:0]  contador_erros
);

    logic        v1_q, v1_d, v2_q, v2_d;
    logic [14:0] cw_q, cw_d;
    logic [3:0]  sin1_q, sin1_d;
    logic [10:0] saida_q, saida_d;
    logic [3:0]  sin2_q, sin2_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        load1, load2;
    logic [3:0]  sin_in;
    logic [14:0] cw_fix;

    assign load2 = !v2_q || saida_pronta;
    assign load1 = !v1_q || load2;

    // Each set bit contributes its 1-based position to the syndrome.
    always_comb begin
        sin_in = '0;
        for (int i = 0; i < 15; i++) begin
            if (entrada[i]) sin_in = sin_in ^ 4'(i + 1);
        end
    end

    always_comb begin
        cw_fix = cw_q;
        if (sin1_q != 4'd0) cw_fix = cw_q ^ (15'd1 << (sin1_q - 4'd1));
    end

    always_comb begin
        v1_d    = load1 ? entrada_valida : v1_q;
        v2_d    = load2 ? v1_q : v2_q;
        cw_d    = cw_q;
        sin1_d  = sin1_q;
        saida_d = saida_q;
        sin2_d  = sin2_q;
        err_d   = err_q;
        if (load1 && entrada_valida) begin
            cw_d   = entrada;
            sin1_d = sin_in;
        end
        // Data bits live at the non-power-of-two positions 3,5,6,7,9..15.
        if (load2 && v1_q) begin
            saida_d = {cw_fix[14:8], cw_fix[6:4], cw_fix[2]};
            sin2_d  = sin1_q;
            err_d   = (sin1_q != 4'd0);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (limpa_contador)
            cnt_d = '0;
        else if (v2_q && saida_pronta && err_q && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            cw_q    <= '0;
            sin1_q  <= '0;
            saida_q <= '0;
            sin2_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            cw_q    <= cw_d;
            sin1_q  <= sin1_d;
            saida_q <= saida_d;
            sin2_q  <= sin2_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign entrada_pronta = load1;
    assign saida_valida   = v2_q;
    assign saida          = saida_q;
    assign sindrome       = sin2_q;
    assign erro_corrigido = err_q;
    assign contador_erros = cnt_q;

endmodule

// File: tb/tb_decodifica_hamming.sv
// Bench for decodifica_hamming: nearest-codeword reference model with an
// in-order scoreboard, checked every cycle, plus literal directed cases.
module tb_decodifica_hamming;

    logic        clk = 1'b0;
    logic        rst;
    logic        entrada_valida;
    logic [14:0] entrada;
    logic        entrada_pronta;
    logic [10:0] saida;
    logic        saida_valida;
    logic        saida_pronta;
    logic        erro_corrigido;
    logic [3:0]  sindrome;
    logic        limpa_contador;
    logic [7:0]  contador_erros;

    decodifica_hamming dut (
        .clk(clk), .rst(rst),
        .entrada_valida(entrada_valida), .entrada(entrada), .entrada_pronta(entrada_pronta),
        .saida(saida), .saida_valida(saida_valida), .saida_pronta(saida_pronta),
        .erro_corrigido(erro_corrigido), .sindrome(sindrome),
        .limpa_contador(limpa_contador), .contador_erros(contador_erros)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] d;
        logic [3:0]  s;
        logic        e;
        int          acc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_low = -100;
    int cnt_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    // A word is a codeword when the XOR of the positions of its set bits is zero.
    function automatic bit is_cw(input logic [14:0] w);
        int x = 0;
        for (int i = 0; i < 15; i++) if (w[i]) x = x ^ (i + 1);
        return x == 0;
    endfunction

    // Decode by searching for the nearest codeword (no flip, or one of 15 flips).
    function automatic exp_t model(input logic [14:0] w, input int acc);
        exp_t r;
        logic [14:0] c, t;
        bit found;
        int k;
        c = w; found = 0; r.s = 4'd0;
        for (int f = 0; f <= 15; f++) begin
            t = w;
            if (f > 0) t[f-1] = ~t[f-1];
            if (!found && is_cw(t)) begin
                found = 1; c = t; r.s = 4'(f);
            end
        end
        r.e = (r.s != 4'd0);
        r.d = '0;
        k = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                r.d[k] = c[p-1];
                k++;
            end
        end
        r.acc = acc;
        return r;
    endfunction

    // Scoreboard / compare process, sampling on the falling edge.
    always @(negedge clk) begin
        bit xfer, xerr;
        cyc++;
        xfer = 0; xerr = 0;
        if (rst) begin
            q.delete();
            cnt_m = 0;
            chk("rst_saida_valida", saida_valida, 0);
            chk("rst_entrada_pronta", entrada_pronta, 1);
            chk("rst_contador", contador_erros, 0);
            chk("rst_saida", {saida, sindrome, erro_corrigido}, 0);
        end else begin
            chk("contador", contador_erros, cnt_m);
            chk("entrada_pronta", entrada_pronta, (q.size() < 2) || saida_pronta);
            if (q.size() == 0) begin
                chk("no_stale_valid", saida_valida, 0);
            end else if (saida_valida) begin
                chk("saida", saida, q[0].d);
                chk("sindrome", sindrome, q[0].s);
                chk("erro_corrigido", erro_corrigido, q[0].e);
                if (last_low < q[0].acc) chk("latency", cyc - q[0].acc, 2);
                if (saida_pronta) begin
                    xfer = 1; xerr = q[0].e;
                    void'(q.pop_front());
                end
            end else if (last_low < q[0].acc && q[0].acc + 2 <= cyc) begin
                chk("latency_valid", saida_valida, 1);
            end
            if (limpa_contador) cnt_m = 0;
            else if (xfer && xerr && cnt_m < 255) cnt_m++;
            if (entrada_valida && entrada_pronta) q.push_back(model(entrada, cyc));
            if (!saida_pronta) last_low = cyc;
        end
    end

    task automatic idle(input int n);
        entrada_valida = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [14:0] w, output int waits);
        bit a, done;
        entrada_valida = 1'b1;
        entrada = w;
        waits = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            a = entrada_pronta;
            @(posedge clk); #1;
            if (a) done = 1;
            else begin
                waits++;
                if (waits > 50) begin
                    chk("send_timeout", 1, 0);
                    done = 1;
                end
            end
        end
        entrada_valida = 1'b0;
    endtask

    // Send one word into an empty pipeline and check it two cycles later.
    task automatic run_lit(input logic [14:0] w, input logic [10:0] ed, input logic [3:0] es, input logic ee);
        int wt;
        saida_pronta = 1'b1;
        idle(3);
        send(w, wt);
        @(posedge clk); #1;
        chk("lit_valid", saida_valida, 1);
        chk("lit_saida", saida, ed);
        chk("lit_sindrome", sindrome, es);
        chk("lit_erro", erro_corrigido, ee);
    endtask

    task automatic rnd_cycle();
        bit a;
        @(negedge clk);
        a = entrada_valida && entrada_pronta;
        @(posedge clk); #1;
        if (!entrada_valida || a) begin
            entrada_valida = ($urandom_range(0, 9) < 7);
            entrada = 15'($urandom);
        end
        saida_pronta = ($urandom_range(0, 3) != 0);
        limpa_contador = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        exp_t m;
        int wt;
        rst = 1'b1;
        entrada_valida = 1'b0;
        entrada = '0;
        saida_pronta = 1'b0;
        limpa_contador = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pronta", entrada_pronta, 1);
        chk("reset_valida", saida_valida, 0);

        m = model(15'h0007, 0); chk("model_clean", {m.d, m.s, m.e}, {11'h001, 4'd0, 1'b0});
        m = model(15'h0003, 0); chk("model_data_err", {m.d, m.s, m.e}, {11'h001, 4'd3, 1'b1});
        m = model(15'h3FFF, 0); chk("model_top_err", {m.d, m.s, m.e}, {11'h7FF, 4'd15, 1'b1});

        rst = 1'b0;
        saida_pronta = 1'b1;
        send(15'h0007, wt);
        chk("first_accept_waits", wt, 0);

        run_lit(15'h0007, 11'h001, 4'd0,  1'b0);
        run_lit(15'h0003, 11'h001, 4'd3,  1'b1);
        run_lit(15'h0006, 11'h001, 4'd1,  1'b1);
        run_lit(15'h3FFF, 11'h7FF, 4'd15, 1'b1);
        run_lit(15'h0004, 11'h000, 4'd3,  1'b1);
        idle(3);
        chk("count_after_lits", contador_erros, 4);

        // Backpressure: two words fill the pipe, the third must wait.
        saida_pronta = 1'b0;
        idle(2);
        send(15'h0007, wt);
        send(15'h0003, wt);
        entrada_valida = 1'b1;
        entrada = 15'h3FFF;
        repeat (3) begin
            @(negedge clk);
            chk("bp_pronta_low", entrada_pronta, 0);
            @(posedge clk); #1;
        end
        saida_pronta = 1'b1;
        send(15'h3FFF, wt);
        send(15'h0006, wt);
        idle(4);

        // Saturation, then clear colliding with an increment.
        for (int i = 0; i < 256; i++) send(15'h0003, wt);
        idle(4);
        chk("sat_255", contador_erros, 255);
        run_lit(15'h0003, 11'h001, 4'd3, 1'b1);
        idle(2);
        chk("sat_hold", contador_erros, 255);
        run_lit(15'h0003, 11'h001, 4'd3, 1'b1);
        limpa_contador = 1'b1;
        @(posedge clk); #1;
        limpa_contador = 1'b0;
        chk("clear_wins_sat", contador_erros, 0);
        run_lit(15'h0006, 11'h001, 4'd1, 1'b1);
        @(posedge clk); #1;
        chk("count_one", contador_erros, 1);
        run_lit(15'h0003, 11'h001, 4'd3, 1'b1);
        limpa_contador = 1'b1;
        @(posedge clk); #1;
        limpa_contador = 1'b0;
        chk("clear_wins", contador_erros, 0);

        repeat (2000) rnd_cycle();

        // Reset in the middle of traffic.
        saida_pronta = 1'b0;
        entrada_valida = 1'b1;
        entrada = 15'h0003;
        @(posedge clk); #1;
        rst = 1'b1;
        entrada_valida = 1'b0;
        limpa_contador = 1'b0;
        #1;
        chk("midrst_valida", saida_valida, 0);
        chk("midrst_pronta", entrada_pronta, 1);
        chk("midrst_contador", contador_erros, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        saida_pronta = 1'b1;
        idle(6);
        chk("post_rst_no_stale", saida_valida, 0);
        send(15'h0007, wt);
        chk("post_rst_first_accept", wt, 0);
        idle(4);
        chk("drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
